regfile_alu_seq: RTL and testbench

REGFILE_ALU_SEQ -- requirements
Module: regfile_alu_seq

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/regfile_alu_seq_if.sv | 15 +
 rtl/regfile_alu.sv | 43 ++++
 rtl/regfile_alu_seq.sv | 123 ++++++++++++
 tb/tb_regfile_alu_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file ALU sequencer: default widths,
// opcode encoding and FSM state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int IMM_W      = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_LI  = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // NOP is the only opcode that leaves the result, flags and register file untouched
    function automatic logic is_nop(input logic [2:0] op);
        return (op == OP_NOP);
    endfunction

endpackage

// File: rtl/regfile_alu_seq_if.sv
// Instruction-issue channel: valid/ready handshake plus the decoded fields.
interface regfile_alu_seq_if #(
    parameter int ADDR_W = 3
) ();
    logic              InstrValid;
    logic              InstrReady;
    logic [2:0]        Opcode;
    logic [ADDR_W-1:0] Rd;
    logic [ADDR_W-1:0] Rs;
    logic [ADDR_W-1:0] Rt;
    logic [7:0]        Imm;

    modport master (output InstrValid, Opcode, Rd, Rs, Rt, Imm, input InstrReady);
    modport slave  (input InstrValid, Opcode, Rd, Rs, Rt, Imm, output InstrReady);
endinterface

// File: rtl/regfile_alu.sv
// Combinational ALU: computes the result and carry/borrow for one opcode.
module regfile_alu
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic [2:0]        opcode_i,
    input  logic [7:0]        imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum_s;

    // Opcode decode; carry is only meaningful for ADD (carry-out) and SUB (borrow)
    always_comb begin
        sum_s    = {1'b0, opa_i} + {1'b0, opb_i};
        result_o = '0;
        carry_o  = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                result_o = sum_s[DATA_W-1:0];
                carry_o  = sum_s[DATA_W];
            end
            OP_SUB: begin
                result_o = opa_i - opb_i;
                carry_o  = (opa_i < opb_i);
            end
            OP_AND:  result_o = opa_i & opb_i;
            OP_OR:   result_o = opa_i | opb_i;
            OP_XOR:  result_o = opa_i ^ opb_i;
            OP_SHL:  result_o = opa_i << opb_i[3:0];
            OP_LI:   result_o = {{(DATA_W-8){imm_i[7]}}, imm_i};
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_alu_seq.sv
// Four-state instruction sequencer: accepts an instruction, reads two
// registers, executes on the ALU and writes the result back.
module regfile_alu_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    regfile_alu_seq_if.slave  instr,
    output logic [ADDR_W-1:0] ReadRegEven,
    output logic [ADDR_W-1:0] ReadRegOdd,
    input  logic [DATA_W-1:0] ReadDataEven,
    input  logic [DATA_W-1:0] ReadDataOdd,
    output logic              WriteEn,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              Done,
    output logic [DATA_W-1:0] Result,
    output logic              Carry,
    output logic              Zero
);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
    logic [7:0]        imm_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [DATA_W-1:0] result_q, wdata_q;
    logic [ADDR_W-1:0] wreg_q;
    logic              carry_q, zero_q, we_q, done_q;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_carry_s;
    logic              exec_wr_s;

    regfile_alu #(.DATA_W(DATA_W)) u_alu (
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .opcode_i (op_q),
        .imm_i    (imm_q),
        .result_o (alu_res_s),
        .carry_o  (alu_carry_s)
    );

    assign instr.InstrReady = (state_q == ST_IDLE) && rst;
    assign exec_wr_s        = (state_q == ST_EXEC) && !is_nop(op_q);
    assign ReadRegEven      = rs_q;
    assign ReadRegOdd       = rt_q;
    assign WriteEn          = we_q;
    assign WriteReg         = wreg_q;
    assign WriteData        = wdata_q;
    assign Done             = done_q;
    assign Result           = result_q;
    assign Carry            = carry_q;
    assign Zero             = zero_q;

    // Next-state logic: only IDLE waits on the handshake, the rest advance every cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (instr.InstrValid) state_d = ST_READ;
                else                  state_d = ST_IDLE;
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register, instruction latch and operand capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= 8'd0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && instr.InstrValid) begin
                op_q  <= instr.Opcode;
                rd_q  <= instr.Rd;
                rs_q  <= instr.Rs;
                rt_q  <= instr.Rt;
                imm_q <= instr.Imm;
            end
            if (state_q == ST_READ) begin
                opa_q <= ReadDataEven;
                opb_q <= ReadDataOdd;
            end
        end
    end

    // Result/flags and write-port registers; WRITE-state strobes are armed at the end of EXEC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q   <= exec_wr_s;
            done_q <= (state_q == ST_EXEC);
            if (exec_wr_s) begin
                result_q <= alu_res_s;
                carry_q  <= alu_carry_s;
                zero_q   <= (alu_res_s == '0);
                wreg_q   <= rd_q;
                wdata_q  <= alu_res_s;
            end
        end
    end

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Directed self-checking bench: drives regfile_alu_seq against an 8x16
// register file and checks results, flags, timing and reset behaviour.
module tb_regfile_alu_seq;
    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  ReadRegEven, ReadRegOdd, WriteReg;
    logic [15:0] ReadDataEven, ReadDataOdd, WriteData, Result;
    logic        WriteEn, Done, Carry, Zero;

    logic [15:0] rf [8] = '{default: 16'h0000};
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [7:0]  imm;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    regfile_alu_seq_if #(.ADDR_W(3)) bus ();

    regfile_alu_seq #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (bus),
        .ReadRegEven  (ReadRegEven),
        .ReadRegOdd   (ReadRegOdd),
        .ReadDataEven (ReadDataEven),
        .ReadDataOdd  (ReadDataOdd),
        .WriteEn      (WriteEn),
        .WriteReg     (WriteReg),
        .WriteData    (WriteData),
        .Done         (Done),
        .Result       (Result),
        .Carry        (Carry),
        .Zero         (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file the block is connected to: combinational read, clocked write
    assign ReadDataEven = rf[ReadRegEven];
    assign ReadDataOdd  = rf[ReadRegOdd];
    always @(posedge clk) begin
        if (WriteEn) rf[WriteReg] <= WriteData;
    end

    // Strobe counters used to prove that no write/done escapes an aborted instruction
    always @(posedge clk) begin
        if (WriteEn === 1'b1) we_cnt <= we_cnt + 1;
        if (Done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [7:0] imm, output int lat,
                          output logic we, output logic [2:0] wreg, output logic [15:0] wdata);
        @(negedge clk);
        bus.InstrValid = 1'b1;
        bus.Opcode = op; bus.Rd = rd; bus.Rs = rs; bus.Rt = rt; bus.Imm = imm;
        @(posedge clk);
        @(negedge clk);
        bus.InstrValid = 1'b0;
        lat = 0; we = 1'b0; wreg = 3'd0; wdata = 16'h0000;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) @(negedge clk);
            if (Done === 1'b1) begin
                lat = i; we = WriteEn; wreg = WriteReg; wdata = WriteData;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.InstrValid = 1'b0;
        bus.Opcode = 3'd0; bus.Rd = 3'd0; bus.Rs = 3'd0; bus.Rt = 3'd0; bus.Imm = 8'd0;
        #2;
        checks++; if (bus.InstrReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.InstrReady); end
        checks++; if (WriteEn !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", WriteEn); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", Done); end
        checks++; if ({Result, WriteData} !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", {Result, WriteData}); end
        checks++; if ({Carry, Zero} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {Carry, Zero}); end
        checks++; if ({WriteReg, ReadRegEven, ReadRegOdd} !== 9'h0) begin errors++; $display("FAIL rst_idx got %h want 0", {WriteReg, ReadRegEven, ReadRegOdd}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.InstrReady !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", bus.InstrReady); end
    endtask

    task automatic test_arith();
        vec_t        v [11];
        int          lat;
        logic        we;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        v = '{
            '{OP_LI,  3'd1, 3'd0, 3'd0, 8'h7F, 16'h007F, 1'b0, 1'b0},
            '{OP_LI,  3'd2, 3'd0, 3'd0, 8'h80, 16'hFF80, 1'b0, 1'b0},
            '{OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 16'hFFFF, 1'b0, 1'b0},
            '{OP_ADD, 3'd4, 3'd3, 3'd1, 8'h00, 16'h007E, 1'b1, 1'b0},
            '{OP_SUB, 3'd5, 3'd1, 3'd1, 8'h00, 16'h0000, 1'b0, 1'b1},
            '{OP_SUB, 3'd6, 3'd1, 3'd2, 8'h00, 16'h00FF, 1'b1, 1'b0},
            '{OP_AND, 3'd0, 3'd1, 3'd2, 8'h00, 16'h0000, 1'b0, 1'b1},
            '{OP_OR,  3'd0, 3'd1, 3'd2, 8'h00, 16'hFFFF, 1'b0, 1'b0},
            '{OP_SHL, 3'd0, 3'd1, 3'd6, 8'h00, 16'h8000, 1'b0, 1'b0},
            '{OP_XOR, 3'd7, 3'd1, 3'd2, 8'h00, 16'hFFFF, 1'b0, 1'b0},
            '{OP_ADD, 3'd4, 3'd3, 3'd1, 8'h00, 16'h007E, 1'b1, 1'b0}
        };
        for (int i = 0; i < 11; i++) begin
            run_op(v[i].op, v[i].rd, v[i].rs, v[i].rt, v[i].imm, lat, we, wreg, wdata);
            checks++; if (lat !== 3) begin errors++; $display("FAIL arith%0d_latency got %0d want 3", i, lat); end
            checks++; if (we !== 1'b1) begin errors++; $display("FAIL arith%0d_we got %b want 1", i, we); end
            checks++; if (wreg !== v[i].rd) begin errors++; $display("FAIL arith%0d_wreg got %0d want %0d", i, wreg, v[i].rd); end
            checks++; if (wdata !== v[i].res) begin errors++; $display("FAIL arith%0d_wdata got %h want %h", i, wdata, v[i].res); end
            checks++; if (rf[v[i].rd] !== v[i].res) begin errors++; $display("FAIL arith%0d_reg got %h want %h", i, rf[v[i].rd], v[i].res); end
            checks++; if (Result !== v[i].res) begin errors++; $display("FAIL arith%0d_result got %h want %h", i, Result, v[i].res); end
            checks++; if (Carry !== v[i].c) begin errors++; $display("FAIL arith%0d_carry got %b want %b", i, Carry, v[i].c); end
            checks++; if (Zero !== v[i].z) begin errors++; $display("FAIL arith%0d_zero got %b want %b", i, Zero, v[i].z); end
        end
    endtask

    task automatic test_nop();
        int          lat;
        logic        we;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        int          we0;
        we0 = we_cnt;
        run_op(OP_NOP, 3'd7, 3'd1, 3'd2, 8'h55, lat, we, wreg, wdata);
        checks++; if (lat !== 3) begin errors++; $display("FAIL nop_latency got %0d want 3", lat); end
        checks++; if (we !== 1'b0 || we_cnt !== we0) begin errors++; $display("FAIL nop_we got %b/%0d want 0/%0d", we, we_cnt, we0); end
        checks++; if (rf[7] !== 16'hFFFF) begin errors++; $display("FAIL nop_r7 got %h want FFFF", rf[7]); end
        checks++; if (Result !== 16'h007E) begin errors++; $display("FAIL nop_result got %h want 007E", Result); end
        checks++; if ({Carry, Zero} !== 2'b10) begin errors++; $display("FAIL nop_flags got %b want 10", {Carry, Zero}); end
        checks++; if (WriteReg !== 3'd4 || WriteData !== 16'h007E) begin errors++; $display("FAIL nop_wport_hold got %0d/%h want 4/007E", WriteReg, WriteData); end
    endtask

    task automatic test_back_to_back();
        vec_t v [3];
        int   idx;
        logic acc;
        v = '{
            '{OP_LI,  3'd5, 3'd0, 3'd0, 8'h01, 16'h0001, 1'b0, 1'b0},
            '{OP_LI,  3'd6, 3'd0, 3'd0, 8'h02, 16'h0002, 1'b0, 1'b0},
            '{OP_ADD, 3'd0, 3'd5, 3'd6, 8'h00, 16'h0003, 1'b0, 1'b0}
        };
        idx = 0;
        @(negedge clk);
        bus.InstrValid = 1'b1;
        bus.Opcode = v[0].op; bus.Rd = v[0].rd; bus.Rs = v[0].rs; bus.Rt = v[0].rt; bus.Imm = v[0].imm;
        for (int t = 0; t < 12; t++) begin
            checks++; if (bus.InstrReady !== ((t % 4) == 0)) begin errors++; $display("FAIL b2b_ready_c%0d got %b want %b", t, bus.InstrReady, ((t % 4) == 0)); end
            checks++; if (Done !== ((t % 4) == 3)) begin errors++; $display("FAIL b2b_done_c%0d got %b want %b", t, Done, ((t % 4) == 3)); end
            acc = bus.InstrReady && bus.InstrValid;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    bus.Opcode = v[idx].op; bus.Rd = v[idx].rd; bus.Rs = v[idx].rs;
                    bus.Rt = v[idx].rt; bus.Imm = v[idx].imm;
                end else begin
                    bus.InstrValid = 1'b0;
                end
            end
        end
        checks++; if (idx !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", idx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rf[v[i].rd] !== v[i].res) begin errors++; $display("FAIL b2b_reg%0d got %h want %h", v[i].rd, rf[v[i].rd], v[i].res); end
        end
    endtask

    task automatic test_reset_mid();
        int we0;
        int done0;
        @(negedge clk);
        bus.InstrValid = 1'b1;
        bus.Opcode = OP_ADD; bus.Rd = 3'd1; bus.Rs = 3'd1; bus.Rt = 3'd1; bus.Imm = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bus.InstrValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        we0 = we_cnt;
        done0 = done_cnt;
        rst = 1'b0;
        #1;
        checks++; if ({WriteEn, Done, bus.InstrReady} !== 3'b000) begin errors++; $display("FAIL mid_strobes got %b want 000", {WriteEn, Done, bus.InstrReady}); end
        checks++; if ({Result, WriteData} !== 32'h0) begin errors++; $display("FAIL mid_data got %h want 0", {Result, WriteData}); end
        checks++; if ({Carry, Zero} !== 2'b00) begin errors++; $display("FAIL mid_flags got %b want 00", {Carry, Zero}); end
        checks++; if ({WriteReg, ReadRegEven, ReadRegOdd} !== 9'h0) begin errors++; $display("FAIL mid_idx got %h want 0", {WriteReg, ReadRegEven, ReadRegOdd}); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.InstrReady !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", bus.InstrReady); end
        repeat (6) @(negedge clk);
        checks++; if (we_cnt !== we0 || done_cnt !== done0) begin errors++; $display("FAIL mid_no_strobe got we %0d done %0d want we %0d done %0d", we_cnt, done_cnt, we0, done0); end
        checks++; if (rf[1] !== 16'h007F) begin errors++; $display("FAIL mid_r1 got %h want 007F", rf[1]); end
        checks++; if (Result !== 16'h0000 || bus.InstrReady !== 1'b1) begin errors++; $display("FAIL mid_idle got %h/%b want 0000/1", Result, bus.InstrReady); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_nop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
